// File: rtl/ex_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_stage_pkg                                              |
// | Purpose  : Shared widths, ALU opcodes, mul/div encodings and helpers |
// |            for the execute stage.                                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package ex_stage_pkg;

  localparam int c_data_w = 32;
  localparam int c_addr_w = 5;
  localparam int c_op_w   = 8;

  // ALU opcode map; anything not listed decodes to a zero result
  typedef enum logic [7:0] {
    ALU_NOP  = 8'h00,
    ALU_ADD  = 8'h01,
    ALU_SUB  = 8'h02,
    ALU_AND  = 8'h03,
    ALU_OR   = 8'h04,
    ALU_XOR  = 8'h05,
    ALU_NOR  = 8'h06,
    ALU_SLT  = 8'h07,
    ALU_SLTU = 8'h08,
    ALU_SLL  = 8'h09,
    ALU_SRL  = 8'h0A,
    ALU_SRA  = 8'h0B,
    ALU_LUI  = 8'h0C,
    ALU_MUL  = 8'h0D,
    ALU_DIVU = 8'h0E,
    ALU_REMU = 8'h0F
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  // True for opcodes served by the iterative mul/div unit
  function automatic logic is_mc_op(input logic [c_op_w-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  // Map an ALU opcode onto the mul/div unit's own operation code
  function automatic md_op_e to_md_op(input logic [c_op_w-1:0] op);
    case (op)
      ALU_DIVU: return MD_DIVU;
      ALU_REMU: return MD_REMU;
      default:  return MD_MUL;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_stage_if                                               |
// | Purpose  : ID/EX inputs, flush/stall handshake and EX/MEM outputs of |
// |            the execute stage bundled as one interface.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface ex_stage_if
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int ADDR_W = c_addr_w,
  parameter int OP_W   = c_op_w
) ();

  logic              ex_regfile_we;
  logic [ADDR_W-1:0] ex_regfile_waddr;
  logic [OP_W-1:0]   ex_alu_op;
  logic [DATA_W-1:0] ex_alu_src1;
  logic [DATA_W-1:0] ex_alu_src2;
  logic              ex_mem_re;
  logic              ex_mem_we;
  logic              flush;
  logic              stall_req;
  logic              mem_regfile_we;
  logic [ADDR_W-1:0] mem_regfile_waddr;
  logic [DATA_W-1:0] mem_alu_result;
  logic              mem_mem_re;
  logic              mem_mem_we;

  // Pipeline side: drives ID/EX and flush, observes stall and EX/MEM
  modport master (
    output ex_regfile_we, ex_regfile_waddr, ex_alu_op, ex_alu_src1, ex_alu_src2,
           ex_mem_re, ex_mem_we, flush,
    input  stall_req, mem_regfile_we, mem_regfile_waddr, mem_alu_result,
           mem_mem_re, mem_mem_we
  );

  // Execute stage side
  modport slave (
    input  ex_regfile_we, ex_regfile_waddr, ex_alu_op, ex_alu_src1, ex_alu_src2,
           ex_mem_re, ex_mem_we, flush,
    output stall_req, mem_regfile_we, mem_regfile_waddr, mem_alu_result,
           mem_mem_re, mem_mem_we
  );

endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_muldiv                                                 |
// | Purpose  : Iterative radix-2 unit, one bit per clock: shift-add      |
// |            multiplier (low word) and restoring unsigned divider.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ex_muldiv
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = c_data_w
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kill,
  input  md_op_e            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int c_cnt_w = $clog2(DATA_W);

  // Shared datapath registers:
  //   MUL : r_x = accumulator, r_y = multiplier (shifts right), r_z = multiplicand (shifts left)
  //   DIV : r_x = partial remainder, r_y = dividend shifting out / quotient shifting in, r_z = divisor
  md_state_e          r_state;
  logic [c_cnt_w-1:0] r_cnt;
  md_op_e             r_op;
  logic [DATA_W-1:0]  r_x;
  logic [DATA_W-1:0]  r_y;
  logic [DATA_W-1:0]  r_z;

  logic [DATA_W:0]    w_rem_sh;
  logic [DATA_W:0]    w_diff;

  // Trial subtraction for one restoring-division step; a divisor of zero always
  // "fits", which naturally yields an all-ones quotient and remainder = dividend
  always_comb begin
    w_rem_sh = {r_x, r_y[DATA_W-1]};
    w_diff   = w_rem_sh - {1'b0, r_z};
  end

  // Control FSM plus one datapath iteration per clock while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= MD_MUL;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else if (kill) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_BUSY;
            r_cnt   <= '0;
            r_op    <= op;
            r_x     <= '0;
            if (op == MD_MUL) begin
              r_y <= b;
              r_z <= a;
            end else begin
              r_y <= a;
              r_z <= b;
            end
          end
        end
        S_BUSY: begin
          if (r_op == MD_MUL) begin
            if (r_y[0]) r_x <= r_x + r_z;
            r_y <= r_y >> 1;
            r_z <= r_z << 1;
          end else if (!w_diff[DATA_W]) begin
            r_x <= w_diff[DATA_W-1:0];
            r_y <= {r_y[DATA_W-2:0], 1'b1};
          end else begin
            r_x <= w_rem_sh[DATA_W-1:0];
            r_y <= {r_y[DATA_W-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_w'(DATA_W - 1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state == S_BUSY);
  assign done   = (r_state == S_DONE);
  assign result = (r_op == MD_DIVU) ? r_y : r_x;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_stage                                                  |
// | Purpose  : Execute stage: combinational ALU, iterative mul/div with  |
// |            upstream stall, and the EX/MEM boundary register.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int ADDR_W = c_addr_w,
  parameter int OP_W   = c_op_w
) (
  input logic     clk,
  input logic     rst,
  ex_stage_if.slave bus
);

  localparam int c_sh_w = $clog2(DATA_W);

  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [c_sh_w-1:0] w_shamt;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_is_mc;
  logic              w_md_busy;
  logic              w_md_done;
  logic [DATA_W-1:0] w_md_result;
  logic              w_stall;

  logic              r_regfile_we;
  logic [ADDR_W-1:0] r_regfile_waddr;
  logic [DATA_W-1:0] r_alu_result;
  logic              r_mem_re;
  logic              r_mem_we;

  assign w_op    = bus.ex_alu_op;
  assign w_a     = bus.ex_alu_src1;
  assign w_b     = bus.ex_alu_src2;
  assign w_shamt = w_b[c_sh_w-1:0];
  assign w_is_mc = is_mc_op(w_op);

  // Single-cycle ALU; multi-cycle and unknown opcodes produce zero here
  always_comb begin
    w_alu_result = '0;
    case (w_op)
      ALU_ADD:  w_alu_result = w_a + w_b;
      ALU_SUB:  w_alu_result = w_a - w_b;
      ALU_AND:  w_alu_result = w_a & w_b;
      ALU_OR:   w_alu_result = w_a | w_b;
      ALU_XOR:  w_alu_result = w_a ^ w_b;
      ALU_NOR:  w_alu_result = ~(w_a | w_b);
      ALU_SLT:  w_alu_result = DATA_W'($signed(w_a) < $signed(w_b));
      ALU_SLTU: w_alu_result = DATA_W'(w_a < w_b);
      ALU_SLL:  w_alu_result = w_a << w_shamt;
      ALU_SRL:  w_alu_result = w_a >> w_shamt;
      ALU_SRA:  w_alu_result = DATA_W'($signed(w_a) >>> w_shamt);
      ALU_LUI:  w_alu_result = w_b << 16;
      default:  w_alu_result = '0;
    endcase
  end

  ex_muldiv #(
    .DATA_W (DATA_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (w_is_mc),
    .kill   (bus.flush),
    .op     (to_md_op(w_op)),
    .a      (w_a),
    .b      (w_b),
    .busy   (w_md_busy),
    .done   (w_md_done),
    .result (w_md_result)
  );

  // Stall from the cycle an mc op is seen in IDLE through the last BUSY
  // cycle; DONE releases upstream so the op retires exactly once
  assign w_stall = !rst && !bus.flush &&
                   ((w_is_mc && !w_md_busy && !w_md_done) || w_md_busy);
  assign bus.stall_req = w_stall;

  // EX/MEM register: bubble on flush or stall, mul/div result in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regfile_we    <= 1'b0;
      r_regfile_waddr <= '0;
      r_alu_result    <= '0;
      r_mem_re        <= 1'b0;
      r_mem_we        <= 1'b0;
    end else if (bus.flush || w_stall) begin
      r_regfile_we    <= 1'b0;
      r_regfile_waddr <= '0;
      r_alu_result    <= '0;
      r_mem_re        <= 1'b0;
      r_mem_we        <= 1'b0;
    end else begin
      r_regfile_we    <= bus.ex_regfile_we;
      r_regfile_waddr <= bus.ex_regfile_waddr;
      r_alu_result    <= w_md_done ? w_md_result : w_alu_result;
      r_mem_re        <= bus.ex_mem_re;
      r_mem_we        <= bus.ex_mem_we;
    end
  end

  assign bus.mem_regfile_we    = r_regfile_we;
  assign bus.mem_regfile_waddr = r_regfile_waddr;
  assign bus.mem_alu_result    = r_alu_result;
  assign bus.mem_mem_re        = r_mem_re;
  assign bus.mem_mem_we        = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ex_stage                                               |
// | Purpose  : Self-checking bench for ex_stage against an arithmetic    |
// |            reference model; directed plus randomized operations.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int c_mc_stall = 33;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU written directly from the operation definitions
  function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_LUI:  return b << 16;
      ALU_MUL: begin
        prod = 64'(a) * 64'(b);
        return prod[31:0];
      end
      ALU_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 32'd0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input logic [4:0] wa, input logic re, input logic mw);
    bus.ex_alu_op        = op;
    bus.ex_alu_src1      = a;
    bus.ex_alu_src2      = b;
    bus.ex_regfile_we    = we;
    bus.ex_regfile_waddr = wa;
    bus.ex_mem_re        = re;
    bus.ex_mem_we        = mw;
  endtask

  function automatic logic [31:0] mem_ctrl();
    return 32'({bus.mem_regfile_we, bus.mem_regfile_waddr, bus.mem_mem_re, bus.mem_mem_we});
  endfunction

  // Single-cycle op: caller is at a negedge; result due after one rising edge
  task automatic alu_op(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic we, input logic [4:0] wa, input logic re, input logic mw);
    drive(op, a, b, we, wa, re, mw);
    #1;
    check({tag, " stall"}, 32'(bus.stall_req), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " result"}, bus.mem_alu_result, ref_alu(op, a, b));
    check({tag, " ctrl"}, mem_ctrl(), 32'({we, wa, re, mw}));
  endtask

  // Multi-cycle op: upstream holds while stalled, result follows the release
  task automatic mc_op(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input logic [4:0] wa);
    int n_stall;
    int n_bad;
    n_stall = 0;
    n_bad   = 0;
    @(negedge clk);
    drive(op, a, b, we, wa, 1'b0, 1'b0);
    #1;
    while (bus.stall_req && n_stall < 100) begin
      n_stall++;
      @(negedge clk);
      #1;
      if (mem_ctrl() != 32'd0 || bus.mem_alu_result != 32'd0) n_bad++;
    end
    check({tag, " stall cycles"}, 32'(n_stall), 32'(c_mc_stall));
    check({tag, " bubbles"}, 32'(n_bad), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " result"}, bus.mem_alu_result, ref_alu(op, a, b));
    check({tag, " ctrl"}, mem_ctrl(), 32'({we, wa, 2'b00}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  ops [13];
    logic [7:0]  mc_ops [3];
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    ops    = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
               ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, 8'hA5};
    mc_ops = '{ALU_MUL, ALU_DIVU, ALU_REMU};

    // Reset with a multi-cycle op presented: no stall, outputs cleared
    rst       = 1'b1;
    bus.flush = 1'b0;
    drive(ALU_MUL, 32'd6, 32'd7, 1'b1, 5'd9, 1'b1, 1'b1);
    #1;
    check("reset stall", 32'(bus.stall_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset ctrl", mem_ctrl(), 32'd0);
    check("reset result", bus.mem_alu_result, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    alu_op("add 5+7", ALU_ADD, 32'd5, 32'd7, 1'b1, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    alu_op("slt -1<1", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd4, 1'b0, 1'b0);
    @(negedge clk);
    alu_op("sltu max<1", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    alu_op("sra", ALU_SRA, 32'h8000_0000, 32'd4, 1'b1, 5'd6, 1'b0, 1'b0);
    @(negedge clk);
    alu_op("sub 0-1", ALU_SUB, 32'd0, 32'd1, 1'b1, 5'd7, 1'b0, 1'b0);
    @(negedge clk);
    alu_op("lui", ALU_LUI, 32'd0, 32'h0000_ABCD, 1'b1, 5'd8, 1'b0, 1'b0);
    @(negedge clk);
    alu_op("unknown op", 8'hEE, 32'd3, 32'd4, 1'b1, 5'd10, 1'b1, 1'b1);

    // Randomized single-cycle traffic with random control fields
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 12)];
      a  = $urandom;
      b  = $urandom;
      @(negedge clk);
      alu_op("rand alu", op, a, b, 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
    end

    // Directed multi-cycle cases including divide by zero
    mc_op("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 1'b1, 5'd11);
    mc_op("remu 100/7", ALU_REMU, 32'd100, 32'd7, 1'b1, 5'd12);
    mc_op("mul max*3", ALU_MUL, 32'hFFFF_FFFF, 32'd3, 1'b1, 5'd13);
    mc_op("divu x/0", ALU_DIVU, 32'h1234_5678, 32'd0, 1'b1, 5'd14);
    mc_op("remu 9/0", ALU_REMU, 32'd9, 32'd0, 1'b1, 5'd15);

    // Randomized multi-cycle ops, sometimes with a zero or small divisor
    for (int i = 0; i < 6; i++) begin
      op = mc_ops[$urandom_range(0, 2)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      mc_op("rand mc", op, a, b, 1'($urandom), 5'($urandom));
    end

    // Flush while the divider is mid-iteration (counter at 10)
    @(negedge clk);
    drive(ALU_DIVU, 32'd1000, 32'd3, 1'b1, 5'd16, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    #1;
    check("flush pre stall", 32'(bus.stall_req), 32'd1);
    bus.flush = 1'b1;
    #1;
    check("flush stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk);
    #1;
    check("flush bubble ctrl", mem_ctrl(), 32'd0);
    check("flush bubble result", bus.mem_alu_result, 32'd0);
    bus.flush = 1'b0;
    @(negedge clk);
    alu_op("add after flush", ALU_ADD, 32'd20, 32'd22, 1'b1, 5'd17, 1'b0, 1'b0);

    // Flush together with a fresh mc op: the op must be dropped
    @(negedge clk);
    drive(ALU_MUL, 32'd5, 32'd5, 1'b1, 5'd18, 1'b0, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("flush+mc stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk);
    #1;
    check("flush+mc bubble", mem_ctrl(), 32'd0);
    bus.flush = 1'b0;
    @(negedge clk);
    alu_op("add after drop", ALU_ADD, 32'd1, 32'd2, 1'b1, 5'd19, 1'b0, 1'b1);

    // Reset in the middle of a divide, then a load straight afterwards
    @(negedge clk);
    drive(ALU_DIVU, 32'd500, 32'd9, 1'b1, 5'd20, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk);
    #1;
    check("mid rst ctrl", mem_ctrl(), 32'd0);
    check("mid rst result", bus.mem_alu_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    alu_op("load after rst", ALU_ADD, 32'h0000_1000, 32'h0000_0024, 1'b1, 5'd21, 1'b1, 1'b0);
    mc_op("divu after rst", ALU_DIVU, 32'd500, 32'd9, 1'b1, 5'd22);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
